// File: rtl/add_fu.sv
// =============================================================================
// Module   : add_fu
// Brief    : Tomasulo integer functional unit (ADD/SUB/logic/SLT/shifts) that
//            reports its result over the common data bus.
//            Define ADD_FU_OVF_EN to build the signed-overflow flag.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module add_fu #(
   parameter int LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_vj,
   input  logic [31:0] i_vk,
   input  logic [3:0]  i_rs_tag,
   input  logic        i_cdb_gnt,
   output logic        o_fu_busy,
   output logic        o_cdb_req,
   output logic        o_cdb_valid,
   output logic [3:0]  o_cdb_tag,
   output logic [31:0] o_cdb_data,
   output logic        o_cdb_ovf
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_REQ   = 2'd2;
   localparam logic [1:0] S_BCAST = 2'd3;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   localparam logic [2:0] c_CNT_INIT = 3'(LAT - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [2:0]  r_cnt;
   logic [2:0]  r_op;
   logic [31:0] r_vj;
   logic [31:0] r_vk;
   logic [3:0]  r_tag;
   logic [31:0] r_result;
   logic [31:0] w_result;
   logic [31:0] w_sum;
   logic [31:0] w_diff;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start)      w_state_nxt = S_EXEC;
         S_EXEC:  if (r_cnt == 3'd0) w_state_nxt = S_REQ;
         S_REQ:   if (i_cdb_gnt)    w_state_nxt = S_BCAST;
         S_BCAST: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   assign w_sum  = r_vj + r_vk;
   assign w_diff = r_vj - r_vk;

   always_comb begin
      w_result = 32'd0;
      case (r_op)
         OP_ADD: w_result = w_sum;
         OP_SUB: w_result = w_diff;
         OP_AND: w_result = r_vj & r_vk;
         OP_OR:  w_result = r_vj | r_vk;
         OP_XOR: w_result = r_vj ^ r_vk;
         OP_SLT: w_result = {31'd0, ($signed(r_vj) < $signed(r_vk))};
         OP_SLL: w_result = r_vj << r_vk[4:0];
         OP_SRL: w_result = r_vj >> r_vk[4:0];
         default: w_result = 32'd0;
      endcase
   end

   // Operands are only loaded in IDLE, so they stay frozen for the whole op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= 3'd0;
         r_op     <= 3'd0;
         r_vj     <= 32'd0;
         r_vk     <= 32'd0;
         r_tag    <= 4'd0;
         r_result <= 32'd0;
      end else begin
         if (r_state == S_IDLE && i_start) begin
            r_op  <= i_op;
            r_vj  <= i_vj;
            r_vk  <= i_vk;
            r_tag <= i_rs_tag;
            r_cnt <= c_CNT_INIT;
         end
         if (r_state == S_EXEC) begin
            if (r_cnt != 3'd0) begin
               r_cnt <= r_cnt - 3'd1;
            end else begin
               r_result <= w_result;
            end
         end
      end
   end

`ifdef ADD_FU_OVF_EN
   logic r_ovf;
   logic w_ovf;

   // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
   // result sign departs from operand A.
   always_comb begin
      w_ovf = 1'b0;
      case (r_op)
         OP_ADD:  w_ovf = (r_vj[31] == r_vk[31]) && (w_sum[31]  != r_vj[31]);
         OP_SUB:  w_ovf = (r_vj[31] != r_vk[31]) && (w_diff[31] != r_vj[31]);
         default: w_ovf = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_EXEC && r_cnt == 3'd0) begin
         r_ovf <= w_ovf;
      end
   end
`endif

   // ---------------------------------------------------------------- outputs
   always_comb begin
      o_fu_busy   = (r_state != S_IDLE);
      o_cdb_req   = (r_state == S_REQ);
      o_cdb_valid = (r_state == S_BCAST);
      o_cdb_tag   = 4'd0;
      o_cdb_data  = 32'd0;
      o_cdb_ovf   = 1'b0;
      if (r_state == S_BCAST) begin
         o_cdb_tag  = r_tag;
         o_cdb_data = r_result;
`ifdef ADD_FU_OVF_EN
         o_cdb_ovf  = r_ovf;
`endif
      end
   end

endmodule

`default_nettype wire

// File: doc/add_fu.md
ADD_FU -- requirements
Module: add_fu

Interface
REQ-001 Parameter: LAT, 3, execute latency in cycles from operand capture to first cdb_req; legal range 1..8.
REQ-002 Port: clk input 1 clock; all state updates on rising edge.
REQ-003 Port: rst_n input 1 reset, synchronous, active-low.
REQ-004 Port: start input 1 reservation-station operands ready and instruction dispatched to this unit (level).
REQ-005 Port: op input 3 operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL.
REQ-006 Port: vj input 32 source operand A.
REQ-007 Port: vk input 32 source operand B.
REQ-008 Port: rs_tag input 4 tag of the issuing reservation station; 0 is never a valid tag.
REQ-009 Port: cdb_gnt input 1 common-data-bus arbiter grant.
REQ-010 Port: fu_busy output 1 high in any state other than IDLE.
REQ-011 Port: cdb_req output 1 request for the common data bus.
REQ-012 Port: cdb_valid output 1 one-cycle broadcast strobe.
REQ-013 Port: cdb_tag output 4 tag being broadcast; 0 when cdb_valid low.
REQ-014 Port: cdb_data output 32 result being broadcast; 0 when cdb_valid low.
REQ-015 Port: cdb_ovf output 1 signed-overflow flag accompanying the broadcast.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, REQ, BCAST; all outputs driven from registers or decoded from state only.
REQ-017 IDLE: start=1 at an edge -> capture op, vj, vk, rs_tag; load counter with LAT-1; go EXEC. start=0 -> stay IDLE.
REQ-018 start SHALL be ignored in every state except IDLE; captured operands SHALL not change until return to IDLE.
REQ-019 EXEC: counter nonzero -> decrement, stay; counter zero -> write result register, go REQ.
REQ-020 cdb_req SHALL be 1 exactly in REQ; first cdb_req cycle is LAT cycles after the capture edge.
REQ-021 REQ: cdb_gnt=1 at an edge -> go BCAST; else stay REQ, result held indefinitely.
REQ-022 cdb_gnt in any state other than REQ SHALL be ignored.
REQ-023 BCAST: cdb_valid=1, cdb_tag=captured tag, cdb_data=result for exactly one cycle; next state IDLE unconditionally.
REQ-024 start asserted during BCAST SHALL not be accepted; earliest new capture is the edge after BCAST (one IDLE cycle minimum).
REQ-025 Arithmetic: ADD/SUB modulo 2^32; SLT signed compare, result 1 or 0; SLL/SRL logical, shift amount vk[4:0]; AND/OR/XOR bitwise.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, counter 0, captured op/vj/vk/tag 0, result 0; this takes priority over start and cdb_gnt.
REQ-027 Reset value of every output SHALL be 0; reset mid-EXEC or mid-REQ discards the operation with no broadcast.

Configuration
REQ-028 Macro ADD_FU_OVF_EN defined: cdb_ovf=1 during BCAST when ADD or SUB overflowed as signed 32-bit; 0 for other ops and outside BCAST.
REQ-029 Macro ADD_FU_OVF_EN undefined: cdb_ovf tied 0 and no overflow logic built; all other behaviour identical.

Verification
REQ-030 LAT=3, ADD vj=5 vk=7 tag=3, cdb_gnt held 1 -> cdb_req high 3 cycles after capture, then cdb_valid one cycle with tag 3, data 12.
REQ-031 SUB vj=0 vk=1 tag=2, cdb_gnt withheld 10 cycles -> cdb_req stays high, data held; grant -> broadcast 0xFFFFFFFF, tag 2, once.
REQ-032 ADD vj=0x7FFFFFFF vk=1 -> data 0x80000000; cdb_ovf=1 with ADD_FU_OVF_EN, 0 without.
REQ-033 SLT vj=0xFFFFFFFE vk=1 -> 1; SRL vj=0x80000000 vk=0x21 -> 0x40000000; SLL vj=1 vk=31 -> 0x80000000.
REQ-034 start held high continuously with changing operands -> only values sampled in IDLE used; second capture exactly one cycle after BCAST.
REQ-035 rst_n=0 during REQ -> next cycle all outputs 0, IDLE; no cdb_valid ever issued for the aborted op.
